// File: rtl/multi_rot_pselect_pkg.sv
// Shared types and constants for the rotating multi-grant issue selector.
// Holds the rotation-mode enum, the LFSR constants and the LFSR step function.
package multi_rot_pselect_pkg;

  localparam int RS_SIZE = 8;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    WALKING = 2'd1,
    JUMPING = 2'd2,
    RANDOM  = 2'd3
  } ROTATION_TYPE;

  localparam logic [15:0] PSEL_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] PSEL_LFSR_TAPS = 16'hB400;

  // Galois LFSR: shift right and fold the taps in when the bit shifted out is set.
  function automatic logic [15:0] psel_lfsr_next(input logic [15:0] state);
    logic [15:0] shifted;
    shifted = {1'b0, state[15:1]};
    return state[0] ? (shifted ^ PSEL_LFSR_TAPS) : shifted;
  endfunction

endpackage

// File: rtl/multi_rot_pselect_circ_ffs.sv
// Circular find-first-set: locates the first set bit of vec at or after start,
// wrapping past N-1 back to 0. Reports found, a one-hot vector and a binary index.
module circ_ffs #(
  parameter int N = 8
) (
  input  logic [N-1:0]         vec,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] pos;

  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    pos    = '0;
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int j = N - 1; j >= 0; j--) begin
      pos = start + IDX_W'(j);
      if (vec[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    onehot[idx] = found;
  end

endmodule

// File: rtl/multi_rot_pselect.sv
// Rotating multi-grant priority selector: up to W distinct grants per cycle from a
// rotating pointer, with saturating per-entry ages forcing starved entries first.
module multi_rot_pselect
  import multi_rot_pselect_pkg::*;
#(
  parameter int N     = RS_SIZE,
  parameter int W     = 2,
  parameter int AGE_W = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N-1:0]                  req,
  input  logic                          en,
  input  ROTATION_TYPE                  rotator,
  output logic [W-1:0][N-1:0]           gnt,
  output logic [W-1:0]                  gnt_valid,
  output logic [W-1:0][$clog2(N)-1:0]   gnt_idx
);

  localparam int               IDX_W   = $clog2(N);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [IDX_W-1:0] HALF    = IDX_W'(N / 2);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("multi_rot_pselect: N must be a power of two, at least 2");
  end
  if (W < 1 || W > 4 || W > N) begin : g_bad_w
    $error("multi_rot_pselect: W must be 1..4 and no larger than N");
  end

  logic [IDX_W-1:0]            ptr;
  logic [IDX_W-1:0]            ptr_nxt;
  logic                        jump_toggle;
  logic                        jump_toggle_nxt;
  logic [15:0]                 lfsr;
  logic [15:0]                 lfsr_nxt;
  logic [N-1:0][AGE_W-1:0]     age;
  logic [N-1:0][AGE_W-1:0]     age_nxt;

  logic [N-1:0]                starved;
  logic                        active;
  logic [W:0][N-1:0]           taken;

  logic [W-1:0]                s_found;
  logic [W-1:0][N-1:0]         s_onehot;
  logic [W-1:0][IDX_W-1:0]     s_idx;
  logic [W-1:0]                r_found;
  logic [W-1:0][N-1:0]         r_onehot;
  logic [W-1:0][IDX_W-1:0]     r_idx;
  logic [W-1:0]                sel_found;
  logic [W-1:0][N-1:0]         sel_onehot;
  logic [W-1:0][IDX_W-1:0]     sel_idx;

  // Outputs are forced low whenever the selector is disabled or held in reset.
  assign active = en & reset;

  always_comb begin
    starved = '0;
    for (int i = 0; i < N; i++) begin
      starved[i] = req[i] & (age[i] == AGE_MAX);
    end
  end

  assign taken[0] = '0;

  for (genvar k = 0; k < W; k++) begin : g_port
    logic [N-1:0] starved_masked;
    logic [N-1:0] req_masked;

    assign starved_masked = starved & ~taken[k];
    assign req_masked     = req & ~taken[k];

    circ_ffs #(.N(N)) u_starve_ffs (
      .vec    (starved_masked),
      .start  ('0),
      .found  (s_found[k]),
      .onehot (s_onehot[k]),
      .idx    (s_idx[k])
    );

    circ_ffs #(.N(N)) u_rot_ffs (
      .vec    (req_masked),
      .start  (ptr),
      .found  (r_found[k]),
      .onehot (r_onehot[k]),
      .idx    (r_idx[k])
    );

    assign sel_found[k]  = s_found[k] | r_found[k];
    assign sel_onehot[k] = s_found[k] ? s_onehot[k] : r_onehot[k];
    assign sel_idx[k]    = s_found[k] ? s_idx[k] : r_idx[k];
    assign taken[k+1]    = taken[k] | sel_onehot[k];

    assign gnt[k]       = active ? sel_onehot[k] : '0;
    assign gnt_valid[k] = active & sel_found[k];
    assign gnt_idx[k]   = active ? sel_idx[k] : '0;
  end

  always_comb begin
    lfsr_nxt        = psel_lfsr_next(lfsr);
    ptr_nxt         = ptr;
    jump_toggle_nxt = jump_toggle;
    unique case (rotator)
      NONE:    ptr_nxt = '0;
      WALKING: ptr_nxt = ptr + IDX_W'(1);
      JUMPING: begin
        ptr_nxt         = ptr + HALF + IDX_W'(jump_toggle);
        jump_toggle_nxt = ~jump_toggle;
      end
      RANDOM:  ptr_nxt = lfsr_nxt[IDX_W-1:0];
      default: ptr_nxt = ptr;
    endcase
  end

  // Granted or idle entries restart their wait; waiting ones age up to AGE_MAX.
  always_comb begin
    age_nxt = age;
    for (int i = 0; i < N; i++) begin
      if (!req[i] || taken[W][i]) begin
        age_nxt[i] = '0;
      end else if (age[i] != AGE_MAX) begin
        age_nxt[i] = age[i] + AGE_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the values
  // from before the edge. The per-entry ages are ordinary flops, not a RAM, so
  // they are cleared by reset along with the rest of the state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      jump_toggle <= 1'b0;
      lfsr        <= PSEL_LFSR_SEED;
      age         <= '0;
    end else if (en) begin
      ptr         <= ptr_nxt;
      jump_toggle <= jump_toggle_nxt;
      lfsr        <= lfsr_nxt;
      age         <= age_nxt;
    end
  end

endmodule

// File: tb/tb_multi_rot_pselect.sv
// Directed self-checking bench for multi_rot_pselect (N=8, W=2) with one AGE_W=3
// instance for rotation modes and one AGE_W=2 instance for starvation.
module tb_multi_rot_pselect;
  import multi_rot_pselect_pkg::*;

  logic               clock;
  logic               reset;
  logic [7:0]         req;
  logic               en;
  ROTATION_TYPE       rotator;

  logic [1:0][7:0]    gnt_a;
  logic [1:0]         gv_a;
  logic [1:0][2:0]    idx_a;
  logic [1:0][7:0]    gnt_b;
  logic [1:0]         gv_b;
  logic [1:0][2:0]    idx_b;

  int total = 0;
  int bad   = 0;

  multi_rot_pselect #(.N(8), .W(2), .AGE_W(3)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .en        (en),
    .rotator   (rotator),
    .gnt       (gnt_a),
    .gnt_valid (gv_a),
    .gnt_idx   (idx_a)
  );

  multi_rot_pselect #(.N(8), .W(2), .AGE_W(2)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .en        (en),
    .rotator   (rotator),
    .gnt       (gnt_b),
    .gnt_valid (gv_b),
    .gnt_idx   (idx_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic check_pair_a(input string tag, input int e0, input int e1);
    logic [7:0] oh0;
    logic [7:0] oh1;
    oh0 = 8'h01 << e0;
    oh1 = 8'h01 << e1;
    #1;
    check({tag, ".idx0"}, 32'(idx_a[0]), 32'(e0));
    check({tag, ".idx1"}, 32'(idx_a[1]), 32'(e1));
    check({tag, ".valid"}, 32'(gv_a), 32'h3);
    check({tag, ".gnt0"}, 32'(gnt_a[0]), 32'(oh0));
    check({tag, ".gnt1"}, 32'(gnt_a[1]), 32'(oh1));
  endtask

  task automatic check_pair_b(input string tag, input int e0, input int e1);
    #1;
    check({tag, ".idx0"}, 32'(idx_b[0]), 32'(e0));
    check({tag, ".idx1"}, 32'(idx_b[1]), 32'(e1));
    check({tag, ".valid"}, 32'(gv_b), 32'h3);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".gnt_a"}, 32'(gnt_a), 32'h0);
    check({tag, ".valid_a"}, 32'(gv_a), 32'h0);
    check({tag, ".idx_a"}, 32'(idx_a), 32'h0);
    check({tag, ".gnt_b"}, 32'(gnt_b), 32'h0);
    check({tag, ".valid_b"}, 32'(gv_b), 32'h0);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic lsb;
    lsb = s[0];
    s   = s >> 1;
    if (lsb) s = s ^ 16'hB400;
    return s;
  endfunction

  initial begin
    int          jump_seq [6];
    int          starve0  [5];
    int          starve1  [5];
    logic [15:0] model_lfsr;
    int          model_ptr;

    jump_seq = '{0, 4, 1, 5, 2, 6};
    starve0  = '{0, 0, 0, 2, 0};
    starve1  = '{1, 1, 1, 7, 1};

    // Reset held with everything requesting: no grants, across clock edges too.
    reset   = 1'b0;
    req     = 8'hFF;
    en      = 1'b1;
    rotator = NONE;
    #3;
    check_idle("in_reset");
    cyc();
    cyc();
    check_idle("in_reset_edges");

    // NONE: pointer pinned at 0, so ports always take entries 0 and 1.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_pair_a("none", 0, 1);
      cyc();
    end

    // WALKING with all requesting, including wrap at ptr = 7.
    apply_reset();
    rotator = WALKING;
    for (int i = 0; i < 9; i++) begin
      check_pair_a("walk", i % 8, (i + 1) % 8);
      cyc();
    end

    // JUMPING with all requesting exposes the pointer sequence directly.
    apply_reset();
    rotator = JUMPING;
    for (int i = 0; i < 6; i++) begin
      check_pair_a("jump_ff", jump_seq[i], (jump_seq[i] + 1) % 8);
      cyc();
    end

    // JUMPING with a single requester: port 0 always entry 0, port 1 empty.
    apply_reset();
    req = 8'h01;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("jump_one.idx0", 32'(idx_a[0]), 32'h0);
      check("jump_one.valid", 32'(gv_a), 32'h1);
      check("jump_one.gnt1", 32'(gnt_a[1]), 32'h0);
      check("jump_one.idx1", 32'(idx_a[1]), 32'h0);
      cyc();
    end

    // Sparse request, then gating with en low for three cycles.
    apply_reset();
    rotator = WALKING;
    req     = 8'h10;
    #1;
    check("sparse.idx0", 32'(idx_a[0]), 32'h4);
    check("sparse.valid", 32'(gv_a), 32'h1);
    check("sparse.gnt0", 32'(gnt_a[0]), 32'h10);
    cyc();
    req = 8'hFF;
    check_pair_a("pre_gap", 1, 2);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_idle("gap");
      cyc();
    end
    en = 1'b1;
    check_pair_a("post_gap", 1, 2);
    cyc();
    check_pair_a("post_gap_next", 2, 3);

    // RANDOM: pointer follows the low bits of a reference LFSR. Idle cycles in
    // between clear all ages so starvation never interferes.
    apply_reset();
    rotator    = RANDOM;
    model_lfsr = 16'hACE1;
    model_ptr  = 0;
    for (int c = 0; c < 64; c++) begin
      req = (c % 2 == 0) ? 8'hFF : 8'h00;
      if (c % 2 == 0) begin
        check_pair_a("random", model_ptr, (model_ptr + 1) % 8);
      end else begin
        #1;
        check("random_idle.valid", 32'(gv_a), 32'h0);
      end
      cyc();
      model_lfsr = lfsr_step(model_lfsr);
      model_ptr  = int'(model_lfsr[2:0]);
    end

    // Starvation on the AGE_W=2 instance: entries 2 and 7 reach 3 after three losses.
    apply_reset();
    rotator = NONE;
    req     = 8'b1000_0111;
    for (int i = 0; i < 5; i++) begin
      check_pair_b("starve", starve0[i], starve1[i]);
      cyc();
    end

    // Asynchronous reset in mid-cycle clears the outputs immediately.
    #1;
    reset = 1'b0;
    #1;
    check_idle("async_reset");
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_rot_pselect.md
# multi_rot_pselect

Rotating multi-grant priority selector for the reservation station issue path. Each cycle it grants up to `W` distinct requesting RS entries, one per issue port, ordered from a rotating priority pointer. Per-entry age counters force long-waiting entries to the front. It replaces the single-grant rotating selector in front of the issue ports and supports NONE, WALKING, JUMPING and RANDOM rotation.

## Interface
- `N`, default `RS_SIZE`: number of entries; power of two, at least 2.
- `W`, default 2: grants per cycle; 1..4, with `W <= N`.
- `AGE_W`, default 3: age counter width; `AGE_MAX = 2**AGE_W - 1`.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-entry request.
- `en`  in  1  select enable; when low, gates grants and freezes all state.
- `rotator`  in  `ROTATION_TYPE`  NONE / WALKING / JUMPING / RANDOM.
- `gnt`  out  W×N  per-port one-hot grant; all zero when the port is not valid.
- `gnt_valid`  out  W  port k holds a grant.
- `gnt_idx`  out  W×$clog2(N)  binary index of the port-k grant; 0 when not valid.

## Operation
- **State:**
  - `ptr` ($clog2(N) bits).
  - `jump_toggle`.
  - 16-bit `lfsr`.
  - `age[i]` (AGE_W bits) per entry.
- **Starved set:** `starved[i] = req[i] & (age[i] == AGE_MAX)`.
- **Port 0 selection:** the lowest-index starved entry wins. If no entry is starved, the first set `req` bit scanning `ptr, ptr+1, …` mod N wins.
- **Port k selection:** the same rule over `req` with all entries granted to ports 0..k-1 masked out.
- **Fewer than W requesters:** upper ports get `gnt_valid = 0`.
- **Disabled or in reset:** when `en = 0` or reset is asserted, all outputs are 0.
- **Pointer update** when `en` is high, all arithmetic mod N:
  - NONE: `ptr` goes to 0.
  - WALKING: `ptr + 1`.
  - JUMPING: `ptr + N/2 + jump_toggle`, and `jump_toggle` inverts.
  - RANDOM: `ptr` takes the low $clog2(N) bits of the next LFSR value.
- **LFSR:** Galois form, taps 16'hB400, seed 16'hACE1. It steps every `en` cycle, whatever the rotation mode.
- **Age update** when `en` is high:
  - A granted entry, or one with `req[i] = 0`, clears to 0.
  - An entry that requested but was not granted increments, saturating at `AGE_MAX`.
- **Disabled cycles:** when `en = 0`, `ptr`, `age`, `lfsr` and `jump_toggle` all hold.
- **Rotation mode change:** takes effect at the next update and starts from the current `ptr`.

## Timing
- **Grant path:** fully combinational from `req`, `en`, `ptr` and `age`, with zero-cycle latency. No output register.
- **State update:** on the rising edge of `clock` only. The new `ptr` and ages apply to the next cycle's selection.
- **Reset:** asserting `reset` low immediately sets `ptr = 0`, `jump_toggle = 0`, `lfsr = 16'hACE1`, all ages to 0, and zeroes the outputs, regardless of the clock.
  - After deassertion, the first edge with `en` high updates normally.
- **Reset mid-operation:** in-flight ages are discarded; no grant is produced while reset is low.
- **Wrap-around:** `ptr = N-1` scans `N-1, 0, 1, …`.
- **Overlapping starvation:** when more than W entries are starved at once, the lowest W starved indices win. The rest keep `AGE_MAX` and win on later cycles.

## Structure
- **Shared package/header:**
  - Reuse the existing `ROTATION_TYPE` enum.
  - Add `PSEL_LFSR_SEED` (16'hACE1) and `PSEL_LFSR_TAPS` (16'hB400).
- **Sub-module `circ_ffs #(N)`:**
  - Inputs: `vec`, `start`.
  - Outputs: `found`, one-hot, and binary index of the first set bit at or after `start`, circularly.
- **Instantiation:** W masked instances, one per port. Starved override uses `circ_ffs` with `start = 0`.

## Test plan
Scenarios 1–5 use N=8, W=2, AGE_W=3; scenario 6 uses AGE_W=2.
1. **Reset and NONE:**
   - Hold `reset = 0` with `req = 8'hFF`, `en = 1` → `gnt` and `gnt_valid` are 0.
   - Release, rotator NONE → every cycle `gnt_idx = {1, 0}` (port 0 = 0, port 1 = 1).
2. **WALKING:** `req = 8'hFF` → grant pairs (0,1), (1,2), (2,3) … (7,0) at `ptr = 7`, then (0,1).
3. **JUMPING:** `req = 8'h01` → `ptr` sequence 0, 4, 1, 5, 2, 6. Port 0 index is always 0; port 1 is invalid.
4. **Gating and sparse requests:**
   - `req = 8'h10` → port 0 `idx = 4`, `gnt_valid = 2'b01`.
   - Drop `en` for 3 cycles → outputs 0 and `ptr`/ages unchanged.
   - Raise `en` → same grant as before the gap.
5. **RANDOM:**
   - From reset, `ptr` equals the low 3 bits of successive LFSR states following `16'hACE1`, checked against a reference LFSR model for 32 cycles.
   - All grants are distinct and drawn from `req`.
6. **Starvation (AGE_W=2):**
   - NONE, `req = 8'b1000_0111` → cycles 1–3 grant (0,1).
   - Cycle 4 grants (2,7), because entries 2 and 7 have reached `AGE_MAX = 3`.
   - Their ages then clear; cycle 5 grants (0,1).
   - Assert `reset` asynchronously mid-cycle → outputs 0 within the same cycle.
